// File: rtl/cycle_timebase_pkg.sv
// ---------------------------------------------------------------------------
// cycle_timebase_pkg
// Shared mode encodings for the run-control / timebase block.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cycle_timebase_pkg;

  // Run-control mode encodings presented on the mode input
  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_HALT  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_LIMIT = 2'b11;

endpackage : cycle_timebase_pkg

`default_nettype wire

// File: rtl/cycle_timebase_ce_divider.sv
// ---------------------------------------------------------------------------
// ce_divider
// One clock-enable channel: divides the global tick by a latched divisor and
// emits a one-cycle ce on the last tick of every period.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ce_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;       // phase within the current period
  logic [DIV_W-1:0] div_q;     // divisor governing the current period
  logic             fresh;     // first cycle after reset: divisor not yet captured
  logic [DIV_W-1:0] div_norm;  // live divisor with 0 mapped to 1
  logic [DIV_W-1:0] div_eff;   // divisor in force this cycle
  logic             wrap;

  // Pick the divisor for this period and detect the last phase of it
  always_comb begin
    div_norm = (div == '0) ? ONE : div;
    div_eff  = fresh ? div_norm : div_q;
    wrap     = (cnt == (div_eff - ONE));
    ce       = tick & wrap;
  end

  // Advance phase on ticks; capture a new divisor only when a period closes,
  // so a mid-period divisor change waits for the current period to finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
      fresh <= 1'b1;
    end else begin
      fresh <= 1'b0;
      if (tick && wrap) begin
        cnt   <= '0;
        div_q <= div_norm;
      end else begin
        if (tick) begin
          cnt <= cnt + ONE;
        end
        div_q <= div_eff;
      end
    end
  end

endmodule : ce_divider

`default_nettype wire

// File: rtl/cycle_timebase.sv
// ---------------------------------------------------------------------------
// cycle_timebase
// Run-control and timebase: turns clk into NUM_CH clock-enable trains and
// counts elapsed ticks under RUN / HALT / STEP / LIMIT control.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cycle_timebase
  import cycle_timebase_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    step_req,
  input  logic [CNT_W-1:0]        limit,
  input  logic [NUM_CH*DIV_W-1:0] div,
  output logic                    tick,
  output logic [NUM_CH-1:0]       ce,
  output logic [CNT_W-1:0]        cycle_count,
  output logic                    running,
  output logic                    done
);

  logic             step_prev;   // previous step_req level, primed high by reset
  logic             step_edge;
  logic             advance;     // tick value for the next cycle
  logic [CNT_W:0]   count_inc;   // cycle_count+1 without overflow
  logic [CNT_W:0]   limit_ext;
  logic [CNT_W-1:0] next_count;
  logic             next_ge_limit;

  // Decode the mode into the advance request for the next cycle
  always_comb begin
    step_edge = step_req & ~step_prev;
    count_inc = {1'b0, cycle_count} + {{CNT_W{1'b0}}, 1'b1};
    limit_ext = {1'b0, limit};
    case (mode)
      MODE_RUN:   advance = 1'b1;
      MODE_STEP:  advance = step_edge;
      MODE_LIMIT: advance = ~done & (count_inc < limit_ext);
      default:    advance = 1'b0;
    endcase
  end

  // Saturating tick counter value after this cycle
  always_comb begin
    next_count = cycle_count;
    if (tick && (cycle_count != {CNT_W{1'b1}})) begin
      next_count = cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    next_ge_limit = (next_count >= limit);
  end

  // Step edge detector; a step seen while not in STEP is simply consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_prev <= 1'b1;
    end else begin
      step_prev <= step_req;
    end
  end

  // Registered global enable and elapsed-tick counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick        <= 1'b0;
      cycle_count <= '0;
    end else begin
      tick        <= advance;
      cycle_count <= next_count;
    end
  end

  // Sticky LIMIT completion: set when the count reaches limit, or when LIMIT
  // can make no further progress (covers limit==0); cleared by leaving LIMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else if (mode != MODE_LIMIT) begin
      done <= 1'b0;
    end else if (done || next_ge_limit || (!tick && !advance)) begin
      done <= 1'b1;
    end
  end

  // Free-running status, one cycle behind mode/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else begin
      running <= (mode == MODE_RUN) || ((mode == MODE_LIMIT) && !done);
    end
  end

  // One divider per clock-enable channel
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ce_divider #(
        .DIV_W (DIV_W)
      ) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .div  (div[i*DIV_W +: DIV_W]),
        .ce   (ce[i])
      );
    end
  endgenerate

endmodule : cycle_timebase

`default_nettype wire

// File: tb/tb_cycle_timebase.sv
// ---------------------------------------------------------------------------
// tb_cycle_timebase
// Directed self-checking bench for cycle_timebase.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cycle_timebase;
  import cycle_timebase_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        step_req;
  logic [31:0] limit;
  logic [15:0] div;
  logic        tick;
  logic [1:0]  ce;
  logic [31:0] cycle_count;
  logic        running;
  logic        done;

  int errors = 0;
  int checks = 0;

  cycle_timebase #(
    .NUM_CH (2),
    .DIV_W  (8),
    .CNT_W  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .step_req    (step_req),
    .limit       (limit),
    .div         (div),
    .tick        (tick),
    .ce          (ce),
    .cycle_count (cycle_count),
    .running     (running),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [15:0] d,
                          input logic [31:0] lim, input logic s);
    rst = 1'b1; mode = m; div = d; limit = lim; step_req = s;
    step_cyc();
    step_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(MODE_RUN, 16'h0401, 32'd0, 1'b0);
    checks++;
    if ({tick, ce, cycle_count, running, done} !== 37'd0) begin
      errors++;
      $display("FAIL reset_state got tick=%b ce=%b cnt=%0d run=%b done=%b exp all 0",
               tick, ce, cycle_count, running, done);
    end
  endtask

  task automatic test_run();
    do_reset(MODE_RUN, {8'd4, 8'd1}, 32'd0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] exp_ce;
      step_cyc();
      exp_ce = {(k % 4 == 0), 1'b1};
      checks++;
      if (tick !== 1'b1 || ce !== exp_ce || cycle_count !== 32'(k - 1)) begin
        errors++;
        $display("FAIL run_tick k=%0d got tick=%b ce=%b cnt=%0d exp tick=1 ce=%b cnt=%0d",
                 k, tick, ce, cycle_count, exp_ce, k - 1);
      end
      if (k == 1) begin
        checks++;
        if (running !== 1'b1) begin
          errors++;
          $display("FAIL run_running got=%b exp=1", running);
        end
      end
    end
    mode = MODE_HALT;
    step_cyc();
    checks++;
    if (cycle_count !== 32'd20 || tick !== 1'b0) begin
      errors++;
      $display("FAIL run_count got cnt=%0d tick=%b exp cnt=20 tick=0", cycle_count, tick);
    end
  endtask

  task automatic test_limit();
    int n;
    int nce;
    do_reset(MODE_LIMIT, {8'd1, 8'd1}, 32'd10, 1'b0);
    n = 0; nce = 0;
    for (int k = 1; k <= 30; k++) begin
      step_cyc();
      n   += int'(tick);
      nce += int'(ce[0]);
      if (k == 2) begin
        checks++;
        if (running !== 1'b1) begin
          errors++;
          $display("FAIL limit_running_early got=%b exp=1", running);
        end
      end
    end
    checks++;
    if (n != 10 || nce != 10) begin
      errors++;
      $display("FAIL limit_ticks got ticks=%0d ce0=%0d exp 10 10", n, nce);
    end
    checks++;
    if (cycle_count !== 32'd10 || done !== 1'b1 || running !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL limit_final got cnt=%0d done=%b run=%b tick=%b exp 10 1 0 0",
               cycle_count, done, running, tick);
    end
    // limit==0: done immediately, no ticks
    do_reset(MODE_LIMIT, {8'd1, 8'd1}, 32'd0, 1'b0);
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      step_cyc();
      n += int'(tick);
    end
    checks++;
    if (n != 0 || done !== 1'b1 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL limit_zero got ticks=%0d done=%b cnt=%0d exp 0 1 0", n, done, cycle_count);
    end
  endtask

  task automatic test_step();
    int n;
    int n1;
    logic prev_t;
    logic back2back;
    // step_req high through reset must not grant a step
    do_reset(MODE_STEP, {8'd2, 8'd1}, 32'd0, 1'b1);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      step_cyc();
      n += int'(tick);
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL step_after_reset got ticks=%0d exp 0", n);
    end
    step_req = 1'b0;
    step_cyc();
    n = 0; n1 = 0; prev_t = 1'b0; back2back = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 5; c++) begin
        step_req = (c < 2);
        step_cyc();
        n  += int'(tick);
        n1 += int'(ce[1]);
        if (tick && prev_t) back2back = 1'b1;
        prev_t = tick;
      end
    end
    step_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step_cyc();
      n += int'(tick);
    end
    checks++;
    if (n != 3 || back2back !== 1'b0) begin
      errors++;
      $display("FAIL step_ticks got ticks=%0d back2back=%b exp 3 0", n, back2back);
    end
    checks++;
    if (cycle_count !== 32'd3 || n1 != 1) begin
      errors++;
      $display("FAIL step_count got cnt=%0d ce1=%0d exp 3 1", cycle_count, n1);
    end
    // step edge coinciding with leaving STEP is dropped
    step_req = 1'b1;
    mode = MODE_HALT;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      step_cyc();
      n += int'(tick);
    end
    checks++;
    if (n != 0 || cycle_count !== 32'd3) begin
      errors++;
      $display("FAIL step_drop got ticks=%0d cnt=%0d exp 0 3", n, cycle_count);
    end
  endtask

  task automatic test_div_change();
    do_reset(MODE_RUN, {8'd4, 8'd3}, 32'd0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      logic exp0;
      step_cyc();
      exp0 = (k == 3) || (k == 6) || (k == 11) || (k == 16);
      checks++;
      if (ce[0] !== exp0) begin
        errors++;
        $display("FAIL div_change k=%0d got ce0=%b exp=%b", k, ce[0], exp0);
      end
      if (k == 5) div[7:0] = 8'd5;
    end
  endtask

  task automatic test_async_reset();
    do_reset(MODE_RUN, {8'd4, 8'd1}, 32'd0, 1'b0);
    for (int k = 0; k < 6; k++) step_cyc();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({tick, ce, cycle_count, running, done} !== 37'd0) begin
      errors++;
      $display("FAIL async_reset got tick=%b ce=%b cnt=%0d run=%b done=%b exp all 0",
               tick, ce, cycle_count, running, done);
    end
    step_cyc();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step_cyc();
      checks++;
      if (tick !== 1'b1 || ce[1] !== (k == 4)) begin
        errors++;
        $display("FAIL async_restart k=%0d got tick=%b ce1=%b exp tick=1 ce1=%b",
                 k, tick, ce[1], (k == 4));
      end
    end
  endtask

  task automatic test_halt();
    do_reset(MODE_RUN, {8'd4, 8'd3}, 32'd0, 1'b0);
    for (int k = 1; k <= 5; k++) step_cyc();
    mode = MODE_HALT;
    for (int h = 1; h <= 7; h++) begin
      step_cyc();
      checks++;
      if (tick !== 1'b0 || ce !== 2'b00 || cycle_count !== 32'd5) begin
        errors++;
        $display("FAIL halt_hold h=%0d got tick=%b ce=%b cnt=%0d exp 0 00 5",
                 h, tick, ce, cycle_count);
      end
      if (h == 1) begin
        checks++;
        if (running !== 1'b0) begin
          errors++;
          $display("FAIL halt_running got=%b exp=0", running);
        end
      end
    end
    mode = MODE_RUN;
    for (int k = 6; k <= 9; k++) begin
      logic [1:0] exp_ce;
      step_cyc();
      exp_ce = {(k == 8), (k % 3 == 0)};
      checks++;
      if (tick !== 1'b1 || ce !== exp_ce) begin
        errors++;
        $display("FAIL halt_resume k=%0d got tick=%b ce=%b exp tick=1 ce=%b",
                 k, tick, ce, exp_ce);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = MODE_HALT; step_req = 1'b0; limit = '0; div = '0;
    test_reset();
    test_run();
    test_limit();
    test_step();
    test_div_change();
    test_async_reset();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cycle_timebase

`default_nettype wire
